cdma_img_info_unpack: RTL and testbench
=======================================

CDMA_IMG_INFO_UNPACK -- requirements
Module: cdma_img_info_unpack

Downstream consumer of the 128x11 image request-info FIFO. Pops one 11-bit entry and expands it into per-atom beats with line/surface framing.

Interface
REQ-001 SHALL have parameter LINE_CNT_W, default 13, giving the line counter width.
REQ-002 SHALL have parameter ATOM_W, default 7, giving the atom-count field width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_req, input, 1 bit: FIFO entry valid (FIFO rd_req).
REQ-006 SHALL have port in_ready, output, 1 bit: entry accepted (drives FIFO rd_ready).
REQ-007 SHALL have port in_data, input, 11 bits: the FIFO entry. Fields: [6:0] atom count; [7] eol; [8] eos; [10:9] lane mask.
REQ-008 SHALL have port out_valid, output, 1 bit: beat valid.
REQ-009 SHALL have port out_ready, input, 1 bit: beat accepted by downstream.
REQ-010 SHALL have port out_atom_idx, output, 7 bits: index of the beat within its entry, 0..N-1.
REQ-011 SHALL have port out_mask, output, 2 bits: lane mask of the current entry.
REQ-012 SHALL have port out_eol, output, 1 bit: end-of-line flag, on the last beat of an eol entry only.
REQ-013 SHALL have port out_eos, output, 1 bit: end-of-surface flag, on the last beat of an eos entry only.
REQ-014 SHALL have port line_cnt, output, LINE_CNT_W bits: lines completed in the current surface.
REQ-015 SHALL have port surf_done, output, 1 bit: one-cycle pulse when a surface completes.
REQ-016 SHALL have port err_zero_len, output, 1 bit: sticky flag for a zero-length entry.
REQ-017 SHALL have port err_clr, input, 1 bit: synchronous clear of err_zero_len.

Function
REQ-018 Pop SHALL be defined as in_req && in_ready. in_data SHALL be sampled in the pop cycle only, because FIFO data is valid only alongside rd_req.
REQ-019 FSM SHALL have two states:
  - IDLE: no entry held.
  - EXPAND: entry held, beats pending.
REQ-020 in_ready SHALL be 1 when in IDLE, or when in EXPAND with the last beat accepted this cycle (out_valid && out_ready && idx==N-1). This gives zero-bubble back-to-back entries.
REQ-021 On a pop with count N in 1..127, the FSM SHALL enter (or stay in) EXPAND, with out_valid high in the next cycle, i.e. 1-cycle latency.
REQ-022 In EXPAND, out_valid SHALL stay high until the last beat is accepted. All beat outputs SHALL be registered and held stable while out_valid && !out_ready.
REQ-023 out_atom_idx SHALL start at 0 and increment by 1 per accepted beat. The entry ends when idx==N-1 is accepted; the FSM then goes to IDLE, or reloads if a pop occurs in the same cycle.
REQ-024 On a pop with count 0: no beats, set err_zero_len, drop the entry, stay in (or return to) IDLE.
REQ-025 If err_clr and a new error occur in the same cycle, the set SHALL win.
REQ-026 line_cnt SHALL increment by 1 when a beat with out_eol is accepted, and wrap modulo 2^LINE_CNT_W.
REQ-027 When a beat with out_eos is accepted:
  - line_cnt SHALL become 0 next cycle, even if eol is also set; the clear wins over the increment.
  - surf_done SHALL pulse high for exactly one cycle, the cycle after acceptance.
REQ-028 When out_valid is 0: out_eol, out_eos, out_atom_idx and out_mask SHALL be 0.

Reset
REQ-029 Reset SHALL asynchronously force the following, independent of clock:
  - state = IDLE
  - out_valid = 0, out_atom_idx = 0, out_mask = 0, out_eol = 0, out_eos = 0
  - line_cnt = 0, surf_done = 0, err_zero_len = 0
  - held count = 0
  - in_ready = 1 one cycle after deassertion
REQ-030 Reset mid-EXPAND SHALL discard the held entry. No partial beat SHALL appear after release.

Structure
REQ-031 A shared package SHALL hold the following; RTL SHALL use no literal field offsets:
  - entry field offsets and widths: CNT [6:0], EOL 7, EOS 8, MASK [10:9]
  - the state enum {IDLE, EXPAND}
  - the 11-bit entry typedef
REQ-032 The block SHALL have one natural sub-module, cdma_img_beat_cnt: a loadable down/up counter with a last-beat flag. All other logic SHALL be flat.

Verification
REQ-033 Single entry, no stall: cnt=3, eol=1, eos=0, out_ready=1.
  - Response: 3 beats on consecutive cycles, idx 0,1,2; eol only on idx 2.
  - line_cnt 0->1.
REQ-034 Back-to-back entries: cnt=1 then cnt=2, both with in_req held and out_ready=1.
  - Response: 3 consecutive beats with no bubble.
  - in_ready high in both pop cycles.
REQ-035 Backpressure: cnt=4, out_ready toggling 1,0,0,1,...
  - Response: outputs held stable during stalls; exactly 4 accepted beats; in_ready low until the 4th is accepted.
REQ-036 Surface end: 5 entries with eol=1, the last also eos=1.
  - Response: line_cnt reaches 4, then reads 0 the cycle after the eos beat; surf_done high for exactly 1 cycle.
REQ-037 Zero-length and error clear: pop cnt=0.
  - Response: no out_valid; err_zero_len=1 until err_clr.
  - err_clr together with a second cnt=0 pop leaves err_zero_len=1.
REQ-038 Reset mid-EXPAND: assert reset after beat idx=1 of a cnt=5 entry.
  - Response: all outputs 0 immediately; no beats after release; the next pop cnt=2 yields idx 0,1.

Source files
------------

// File: rtl/cdma_img_info_unpack_pkg.sv
// ----------------------------------------------------------------------------
// cdma_img_info_unpack_pkg
// Shared definitions for the image request-info unpacker:
//   - layout of the 11-bit FIFO entry (field offsets and widths)
//   - entry typedef and field accessor functions
//   - FSM state enumeration
// ----------------------------------------------------------------------------
package cdma_img_info_unpack_pkg;

    localparam int ENTRY_W  = 11;
    localparam int CNT_LSB  = 0;
    localparam int CNT_W    = 7;
    localparam int EOL_BIT  = 7;
    localparam int EOS_BIT  = 8;
    localparam int MASK_LSB = 9;
    localparam int MASK_W   = 2;

    typedef logic [ENTRY_W-1:0] img_entry_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } img_state_e;

    function automatic logic [CNT_W-1:0] entry_cnt(input img_entry_t e);
        return e[CNT_LSB +: CNT_W];
    endfunction

    function automatic logic entry_eol(input img_entry_t e);
        return e[EOL_BIT];
    endfunction

    function automatic logic entry_eos(input img_entry_t e);
        return e[EOS_BIT];
    endfunction

    function automatic logic [MASK_W-1:0] entry_mask(input img_entry_t e);
        return e[MASK_LSB +: MASK_W];
    endfunction

endpackage

// File: rtl/cdma_img_info_unpack_beat_cnt.sv
// ----------------------------------------------------------------------------
// cdma_img_beat_cnt
// Loadable beat counter. idx counts up from 0 per advance; remaining counts
// down from the loaded length, and last flags the final beat of the entry.
// Ports:
//   clk, reset       : clock, async active-high reset
//   load, load_len   : start a new entry of load_len beats (wins over advance)
//   advance          : current beat accepted
//   idx              : index of the current beat
//   remaining        : beats still pending including the current one
//   last             : current beat is the final one
// ----------------------------------------------------------------------------
module cdma_img_beat_cnt #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_len,
    input  logic         advance,
    output logic [W-1:0] idx,
    output logic [W-1:0] remaining,
    output logic         last
);

    logic [W-1:0] idx_q, idx_d;
    logic [W-1:0] rem_q, rem_d;

    always_comb begin
        idx_d = idx_q;
        rem_d = rem_q;
        if (load) begin
            idx_d = '0;
            rem_d = load_len;
        end else if (advance && (rem_q != '0)) begin
            idx_d = idx_q + W'(1);
            rem_d = rem_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
            rem_q <= '0;
        end else begin
            idx_q <= idx_d;
            rem_q <= rem_d;
        end
    end

    assign idx       = idx_q;
    assign remaining = rem_q;
    assign last      = (rem_q == W'(1));

endmodule

// File: rtl/cdma_img_info_unpack.sv
// ----------------------------------------------------------------------------
// cdma_img_info_unpack
// Pops 11-bit entries from the image request-info FIFO and expands each into
// N per-atom beats, framing the last beat with eol/eos and tracking lines
// completed per surface.
// Ports:
//   clk, reset            : clock, async active-high reset
//   in_req/in_ready/in_data : FIFO read handshake and entry
//   out_valid/out_ready   : beat handshake
//   out_atom_idx/out_mask/out_eol/out_eos : beat payload (0 when not valid)
//   line_cnt, surf_done   : line counter and surface-complete pulse
//   err_zero_len, err_clr : sticky zero-length error and its clear
// ----------------------------------------------------------------------------
module cdma_img_info_unpack
    import cdma_img_info_unpack_pkg::*;
#(
    parameter int LINE_CNT_W = 13,
    parameter int ATOM_W     = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_req,
    output logic                  in_ready,
    input  logic [10:0]           in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ATOM_W-1:0]     out_atom_idx,
    output logic [1:0]            out_mask,
    output logic                  out_eol,
    output logic                  out_eos,
    output logic [LINE_CNT_W-1:0] line_cnt,
    output logic                  surf_done,
    output logic                  err_zero_len,
    input  logic                  err_clr
);

    img_state_e          state_q, state_d;
    logic                eol_q, eol_d;
    logic                eos_q, eos_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic                surf_done_q, surf_done_d;
    logic                err_q, err_d;

    img_entry_t          in_entry;
    logic [ATOM_W-1:0]   in_cnt;
    logic                pop, pop_valid, pop_zero;
    logic                beat_acc, last_acc;
    logic [ATOM_W-1:0]   beat_idx;
    logic [ATOM_W-1:0]   beat_rem;
    logic                beat_last;

    assign in_entry = img_entry_t'(in_data);
    assign in_cnt   = ATOM_W'(entry_cnt(in_entry));

    assign out_valid = (state_q == ST_EXPAND);
    assign beat_acc  = out_valid && out_ready;
    assign last_acc  = beat_acc && beat_last;

    // Accepting while the final beat drains lets the next entry follow with
    // no idle cycle in between.
    assign in_ready  = (state_q == ST_IDLE) || last_acc;

    assign pop       = in_req && in_ready;
    assign pop_valid = pop && (in_cnt != '0);
    assign pop_zero  = pop && (in_cnt == '0);

    cdma_img_beat_cnt #(
        .W (ATOM_W)
    ) u_beat_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (pop_valid),
        .load_len  (in_cnt),
        .advance   (beat_acc),
        .idx       (beat_idx),
        .remaining (beat_rem),
        .last      (beat_last)
    );

    always_comb begin
        state_d     = state_q;
        eol_d       = eol_q;
        eos_d       = eos_q;
        mask_d      = mask_q;
        line_cnt_d  = line_cnt_q;
        surf_done_d = 1'b0;
        err_d       = err_q;

        if (pop_valid) begin
            state_d = ST_EXPAND;
            eol_d   = entry_eol(in_entry);
            eos_d   = entry_eos(in_entry);
            mask_d  = entry_mask(in_entry);
        end else if (last_acc) begin
            state_d = ST_IDLE;
            eol_d   = 1'b0;
            eos_d   = 1'b0;
            mask_d  = '0;
        end

        // Surface end resets the line count even if the same beat ends a line.
        if (beat_acc && out_eos) begin
            line_cnt_d  = '0;
            surf_done_d = 1'b1;
        end else if (beat_acc && out_eol) begin
            line_cnt_d = line_cnt_q + LINE_CNT_W'(1);
        end

        // A new error in the same cycle as a clear keeps the flag set.
        if (pop_zero) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            eol_q       <= 1'b0;
            eos_q       <= 1'b0;
            mask_q      <= '0;
            line_cnt_q  <= '0;
            surf_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            eol_q       <= eol_d;
            eos_q       <= eos_d;
            mask_q      <= mask_d;
            line_cnt_q  <= line_cnt_d;
            surf_done_q <= surf_done_d;
            err_q       <= err_d;
        end
    end

    // Payload is built only from flops and forced to 0 outside a beat.
    assign out_atom_idx = out_valid ? beat_idx : '0;
    assign out_mask     = out_valid ? mask_q : '0;
    assign out_eol      = out_valid && eol_q && beat_last;
    assign out_eos      = out_valid && eos_q && beat_last;

    assign line_cnt     = line_cnt_q;
    assign surf_done    = surf_done_q;
    assign err_zero_len = err_q;

endmodule

// File: tb/tb_cdma_img_info_unpack.sv
module tb_cdma_img_info_unpack;

    logic        clk;
    logic        reset;
    logic        in_req;
    logic        in_ready;
    logic [10:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_atom_idx;
    logic [1:0]  out_mask;
    logic        out_eol;
    logic        out_eos;
    logic [12:0] line_cnt;
    logic        surf_done;
    logic        err_zero_len;
    logic        err_clr;

    int n_tests = 0;
    int n_fail  = 0;

    cdma_img_info_unpack #(
        .LINE_CNT_W (13),
        .ATOM_W     (7)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_req       (in_req),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_atom_idx (out_atom_idx),
        .out_mask     (out_mask),
        .out_eol      (out_eol),
        .out_eos      (out_eos),
        .line_cnt     (line_cnt),
        .surf_done    (surf_done),
        .err_zero_len (err_zero_len),
        .err_clr      (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] mk(input logic [1:0] mask, input logic eos,
                                       input logic eol, input logic [6:0] cnt);
        return {mask, eos, eol, cnt};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0b exp 0", out_valid); end
        n_tests++;
        if (line_cnt !== 13'd0) begin n_fail++; $display("FAIL rst_line got %0d exp 0", line_cnt); end
        n_tests++;
        if ({surf_done, err_zero_len, out_eol, out_eos} !== 4'b0) begin
            n_fail++; $display("FAIL rst_flags got %b exp 0000", {surf_done, err_zero_len, out_eol, out_eos});
        end
        reset = 1'b0;
        step();
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %0b exp 1", in_ready); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_req    = 1'b1;
        in_data   = mk(2'b01, 1'b0, 1'b1, 7'd3);
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready got %0b exp 1", in_ready); end
        step();
        in_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_atom_idx !== 7'(i) || out_mask !== 2'b01 ||
                out_eol !== (i == 2) || out_eos !== 1'b0) begin
                n_fail++;
                $display("FAIL single_beat%0d got v=%0b idx=%0d m=%0d eol=%0b eos=%0b exp v=1 idx=%0d m=1 eol=%0b eos=0",
                         i, out_valid, out_atom_idx, out_mask, out_eol, out_eos, i, (i == 2));
            end
            step();
        end
        n_tests++;
        if (out_valid !== 1'b0 || line_cnt !== 13'd1) begin
            n_fail++; $display("FAIL single_end got v=%0b line=%0d exp v=0 line=1", out_valid, line_cnt);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_req    = 1'b1;
        in_data   = mk(2'b10, 1'b0, 1'b0, 7'd1);
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_pop1 got %0b exp 1", in_ready); end
        step();
        in_data = mk(2'b11, 1'b0, 1'b0, 7'd2);
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_atom_idx !== 7'd0 || out_mask !== 2'b10 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_beat0 got v=%0b idx=%0d m=%0d rdy=%0b exp v=1 idx=0 m=2 rdy=1",
                     out_valid, out_atom_idx, out_mask, in_ready);
        end
        step();
        in_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_atom_idx !== 7'(i) || out_mask !== 2'b11) begin
                n_fail++;
                $display("FAIL b2b_e2_beat%0d got v=%0b idx=%0d m=%0d exp v=1 idx=%0d m=3",
                         i, out_valid, out_atom_idx, out_mask, i);
            end
            step();
        end
        n_tests++;
        if (out_valid !== 1'b0 || line_cnt !== 13'd1) begin
            n_fail++; $display("FAIL b2b_end got v=%0b line=%0d exp v=0 line=1", out_valid, line_cnt);
        end
    endtask

    task automatic test_backpressure();
        int pat[10] = '{1, 0, 0, 1, 1, 0, 1, 0, 1, 1};
        int exp_idx = 0;
        int c = 0;
        out_ready = 1'b1;
        in_req    = 1'b1;
        in_data   = mk(2'b10, 1'b0, 1'b0, 7'd4);
        step();
        in_req = 1'b0;
        while (exp_idx < 4 && c < 10) begin
            out_ready = pat[c][0];
            #1;
            n_tests++;
            if (out_valid !== 1'b1 || out_atom_idx !== 7'(exp_idx) || out_mask !== 2'b10 ||
                in_ready !== (pat[c] == 1 && exp_idx == 3)) begin
                n_fail++;
                $display("FAIL bp_cyc%0d got v=%0b idx=%0d m=%0d rdy=%0b exp v=1 idx=%0d m=2 rdy=%0b",
                         c, out_valid, out_atom_idx, out_mask, in_ready, exp_idx,
                         (pat[c] == 1 && exp_idx == 3));
            end
            if (pat[c] == 1) exp_idx++;
            c++;
            step();
        end
        out_ready = 1'b1;
        n_tests++;
        if (exp_idx != 4 || c != 7) begin
            n_fail++; $display("FAIL bp_count got beats=%0d cycles=%0d exp beats=4 cycles=7", exp_idx, c);
        end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_end got v=%0b exp 0", out_valid); end
    endtask

    task automatic test_surface();
        int pulses = 0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_req  = 1'b1;
            in_data = mk(2'b01, (k == 4), 1'b1, 7'd1);
            step();
            in_req = 1'b0;
            if (k == 4) begin
                n_tests++;
                if (out_eol !== 1'b1 || out_eos !== 1'b1 || line_cnt !== 13'd4) begin
                    n_fail++;
                    $display("FAIL surf_last_beat got eol=%0b eos=%0b line=%0d exp eol=1 eos=1 line=4",
                             out_eol, out_eos, line_cnt);
                end
            end
            step();
            if (surf_done === 1'b1) pulses++;
            if (k < 4) begin
                n_tests++;
                if (line_cnt !== 13'(k + 1)) begin
                    n_fail++; $display("FAIL surf_line%0d got %0d exp %0d", k, line_cnt, k + 1);
                end
            end
        end
        n_tests++;
        if (line_cnt !== 13'd0 || surf_done !== 1'b1) begin
            n_fail++; $display("FAIL surf_clear got line=%0d sd=%0b exp line=0 sd=1", line_cnt, surf_done);
        end
        for (int j = 0; j < 3; j++) begin
            step();
            if (surf_done === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 1) begin n_fail++; $display("FAIL surf_pulses got %0d exp 1", pulses); end
    endtask

    task automatic test_zero_len();
        int seen_valid = 0;
        in_req  = 1'b1;
        in_data = mk(2'b11, 1'b0, 1'b0, 7'd0);
        step();
        in_req = 1'b0;
        for (int j = 0; j < 3; j++) begin
            if (out_valid === 1'b1) seen_valid++;
            step();
        end
        n_tests++;
        if (seen_valid != 0 || err_zero_len !== 1'b1) begin
            n_fail++; $display("FAIL zl_set got valid_cycles=%0d err=%0b exp 0 err=1", seen_valid, err_zero_len);
        end
        in_req  = 1'b1;
        err_clr = 1'b1;
        step();
        in_req  = 1'b0;
        err_clr = 1'b0;
        n_tests++;
        if (err_zero_len !== 1'b1) begin n_fail++; $display("FAIL zl_set_wins got %0b exp 1", err_zero_len); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_tests++;
        if (err_zero_len !== 1'b0) begin n_fail++; $display("FAIL zl_clear got %0b exp 0", err_zero_len); end
    endtask

    task automatic test_reset_mid();
        int seen_valid = 0;
        out_ready = 1'b1;
        in_req    = 1'b1;
        in_data   = mk(2'b11, 1'b1, 1'b1, 7'd5);
        step();
        in_req = 1'b0;
        step();
        n_tests++;
        if (out_atom_idx !== 7'd1 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL rm_pre got idx=%0d v=%0b exp idx=1 v=1", out_atom_idx, out_valid);
        end
        step();
        reset = 1'b1;
        #1;
        n_tests++;
        if ({out_valid, out_atom_idx, out_mask, out_eol, out_eos} !== 12'd0 ||
            line_cnt !== 13'd0 || surf_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_async got v=%0b idx=%0d m=%0d line=%0d exp all 0",
                     out_valid, out_atom_idx, out_mask, line_cnt);
        end
        step();
        step();
        reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step();
            if (out_valid === 1'b1) seen_valid++;
        end
        n_tests++;
        if (seen_valid != 0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rm_release got valid_cycles=%0d rdy=%0b exp 0 rdy=1", seen_valid, in_ready);
        end
        in_req  = 1'b1;
        in_data = mk(2'b01, 1'b0, 1'b0, 7'd2);
        step();
        in_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_atom_idx !== 7'(i) || out_mask !== 2'b01) begin
                n_fail++;
                $display("FAIL rm_next_beat%0d got v=%0b idx=%0d m=%0d exp v=1 idx=%0d m=1",
                         i, out_valid, out_atom_idx, out_mask, i);
            end
            step();
        end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_next_end got v=%0b exp 0", out_valid); end
    endtask

    initial begin
        reset     = 1'b1;
        in_req    = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_surface();
        test_zero_len();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
